// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer between EX and the unsigned MLU.
// Takes operand magnitudes, waits out the MLU, fixes the sign.
module mul_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_signed_i,
  input  logic        req_to_hilo_i,
  input  logic [31:0] req_op1_i,
  input  logic [31:0] req_op2_i,
  output logic        stallreq_o,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mlu_result_i,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  output logic        hilo_we_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        neg_q;
  logic        to_hilo_q;
  logic        accept;
  logic        sample;
  logic        sgn1;
  logic        sgn2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        neg_d;

  // Request acceptance and operand magnitude/sign preparation
  always_comb begin
    accept = (state_q == IDLE) & req_valid_i & ~flush_i;
    sample = (state_q == RUN) & ~flush_i & (cnt_q == LAT);
    sgn1   = req_signed_i & req_op1_i[31];
    sgn2   = req_signed_i & req_op2_i[31];
    mag1   = sgn1 ? (~req_op1_i + 32'd1) : req_op1_i;
    mag2   = sgn2 ? (~req_op2_i + 32'd1) : req_op2_i;
    neg_d  = req_signed_i & (req_op1_i[31] ^ req_op2_i[31])
           & (|req_op1_i) & (|req_op2_i);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (flush_i)           state_d = IDLE;
        else if (cnt_q == LAT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, captured operands and corrected product
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      neg_q     <= 1'b0;
      to_hilo_q <= 1'b0;
      mul_op1_o <= 32'd0;
      mul_op2_o <= 32'd0;
      result_o  <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= 4'd0;
        mul_op1_o <= mag1;
        mul_op2_o <= mag2;
        neg_q     <= neg_d;
        to_hilo_q <= req_to_hilo_i;
      end else if (state_q == RUN && !flush_i) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (sample) begin
        result_o <= neg_q ? (~mlu_result_i + 64'd1)
                          : mlu_result_i;
      end
    end
  end

  // Handshake, MLU control and completion strobes
  always_comb begin
    req_ready_o    = (state_q == IDLE);
    mul_start_o    = (state_q == RUN);
    mul_sign_o     = 1'b0;
    stallreq_o     = accept | (state_q == RUN);
    result_valid_o = (state_q == DONE);
    hilo_we_o      = (state_q == DONE) & to_hilo_q;
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: randomized and directed checks of mul_ctrl
// against an arithmetic reference model and a stand-in MLU.
module tb_mul_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_signed_i;
  logic        req_to_hilo_i;
  logic [31:0] req_op1_i;
  logic [31:0] req_op2_i;
  logic        stallreq_o;
  logic        mul_start_o;
  logic        mul_sign_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic [63:0] mlu_result_i;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic        hilo_we_o;

  int checks = 0;
  int fails  = 0;

  mul_ctrl #(.LATENCY(LAT)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_signed_i   (req_signed_i),
    .req_to_hilo_i  (req_to_hilo_i),
    .req_op1_i      (req_op1_i),
    .req_op2_i      (req_op2_i),
    .stallreq_o     (stallreq_o),
    .mul_start_o    (mul_start_o),
    .mul_sign_o     (mul_sign_o),
    .mul_op1_o      (mul_op1_o),
    .mul_op2_o      (mul_op2_o),
    .mlu_result_i   (mlu_result_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .hilo_we_o      (hilo_we_o)
  );

  always #5 clk = ~clk;

  // Stand-in MLU: product is valid only LAT edges into a start
  // burst; any other time the result bus carries garbage.
  int          mlu_cnt = 0;
  logic [63:0] garbage = 64'd0;
  always @(posedge clk) begin
    mlu_cnt <= mul_start_o ? mlu_cnt + 1 : 0;
    garbage <= {$urandom, $urandom};
  end
  always_comb begin
    if (mul_start_o && mlu_cnt == LAT)
      mlu_result_i = {32'd0, mul_op1_o} * {32'd0, mul_op2_o};
    else
      mlu_result_i = garbage;
  end

  function automatic logic [63:0] ref_prod(
    input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sg) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    return sa * sb;
  endfunction

  function automatic logic [31:0] ref_mag(
    input logic [31:0] a, input logic sg);
    logic signed [63:0] v;
    v = sg ? {{32{a[31]}}, a} : {32'd0, a};
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  logic [63:0] o_res;
  logic [31:0] o_m1, o_m2;
  logic        o_we, o_ok, o_one;
  logic        o_stall_req, o_ready_req;
  logic        o_stall_done, o_ready_done;
  int          o_n, o_stall, o_ready;
  logic [63:0] last_res;

  // Present one request at the current negedge and follow it
  // to completion; records observations only.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic th,
                        input logic fd);
    req_op1_i = a;
    req_op2_i = b;
    req_signed_i = sg;
    req_to_hilo_i = th;
    req_valid_i = 1'b1;
    #1;
    o_stall_req = stallreq_o;
    o_ready_req = req_ready_o;
    o_ok = 1'b0;
    o_stall = 0;
    o_ready = 0;
    o_n = 0;
    for (int n = 1; n < 40 && !o_ok; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid_i = 1'b0;
        req_op1_i = $urandom;
        req_op2_i = $urandom;
        req_signed_i = ~sg;
        req_to_hilo_i = ~th;
      end
      if (fd && n == LAT + 2) flush_i = 1'b1;
      #1;
      if (result_valid_o) begin
        o_ok = 1'b1;
        o_n = n;
        o_res = result_o;
        o_we = hilo_we_o;
        o_m1 = mul_op1_o;
        o_m2 = mul_op2_o;
        o_stall_done = stallreq_o;
        o_ready_done = req_ready_o;
      end else begin
        o_stall += int'(stallreq_o);
        o_ready += int'(req_ready_o);
      end
    end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    o_one = !result_valid_o && !hilo_we_o;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    req_signed_i = 1'b1;
    req_to_hilo_i = 1'b1;
    req_op1_i = $urandom;
    req_op2_i = $urandom;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready_o, mul_start_o, mul_sign_o, result_valid_o,
         hilo_we_o, stallreq_o} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 100000",
        {req_ready_o, mul_start_o, mul_sign_o, result_valid_o,
         hilo_we_o, stallreq_o});
    end
    checks++;
    if ({mul_op1_o, mul_op2_o, result_o} !== 128'd0) begin
      fails++;
      $display("FAIL reset_data got %h %h %h exp 0",
        mul_op1_o, mul_op2_o, result_o);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic sg,
                          input logic th);
    logic [63:0] exp;
    exp = ref_prod(a, b, sg);
    checks++;
    if (!o_ok) begin
      fails++;
      $display("FAIL %s_timeout no result_valid_o in 40 cycles", nm);
      return;
    end
    checks++;
    if (o_res !== exp) begin
      fails++;
      $display("FAIL %s_result got %h exp %h", nm, o_res, exp);
    end
    checks++;
    if (o_we !== th) begin
      fails++;
      $display("FAIL %s_hilo_we got %b exp %b", nm, o_we, th);
    end
    checks++;
    if ({o_m1, o_m2} !== {ref_mag(a, sg), ref_mag(b, sg)}) begin
      fails++;
      $display("FAIL %s_mag got %h %h exp %h %h", nm, o_m1, o_m2,
        ref_mag(a, sg), ref_mag(b, sg));
    end
    checks++;
    if (o_n !== LAT + 2 || o_stall !== LAT + 1) begin
      fails++;
      $display("FAIL %s_timing got done@%0d stall=%0d exp %0d %0d",
        nm, o_n, o_stall, LAT + 2, LAT + 1);
    end
    checks++;
    if ({o_stall_req, o_ready_req, o_ready, o_stall_done,
         o_ready_done, o_one} !== {2'b11, 32'd0, 3'b001}) begin
      fails++;
      $display("FAIL %s_hs got sr=%b rr=%b rdy=%0d sd=%b rd=%b one=%b",
        nm, o_stall_req, o_ready_req, o_ready, o_stall_done,
        o_ready_done, o_one);
    end
    last_res = exp;
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                            32'h80000000, 32'h00000000};
    logic [31:0] vb [5] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000,
                            32'h00000001, 32'hFFFFFFF9};
    logic        vs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0] ve [5] = '{64'hFFFFFFFE00000001, 64'hFFFFFFFFFFFFFFF1,
                            64'h4000000000000000, 64'hFFFFFFFF80000000,
                            64'h0};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b1, 1'b0);
      checks++;
      if (o_res !== ve[i]) begin
        fails++;
        $display("FAIL dir%0d_const got %h exp %h", i, o_res, ve[i]);
      end
      check_op($sformatf("dir%0d", i), va[i], vb[i], vs[i], 1'b1);
    end
  endtask

  task automatic test_mul_path();
    run_op(32'd7, 32'd6, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_res !== 64'd42 || o_we !== 1'b0) begin
      fails++;
      $display("FAIL mul_path got %h we=%b exp 2a we=0", o_res, o_we);
    end
    check_op("mul_path", 32'd7, 32'd6, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    int vcnt;
    req_op1_i = 32'h12345678;
    req_op2_i = 32'h9ABCDEF0;
    req_signed_i = 1'b1;
    req_to_hilo_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, mul_start_o, result_valid_o, hilo_we_o}
        !== 4'b1000 || result_o !== last_res) begin
      fails++;
      $display("FAIL flush_run got rdy=%b st=%b v=%b we=%b res=%h exp 1000 %h",
        req_ready_o, mul_start_o, result_valid_o, hilo_we_o,
        result_o, last_res);
    end
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      vcnt += int'(result_valid_o | hilo_we_o | mul_start_o);
    end
    checks++;
    if (vcnt !== 0) begin
      fails++;
      $display("FAIL flush_quiet got %0d active cycles exp 0", vcnt);
    end
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_stall got %b exp 0", stallreq_o);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, mul_start_o} !== 2'b10) begin
      fails++;
      $display("FAIL flush_idle_ignore got %b exp 10",
        {req_ready_o, mul_start_o});
    end
    run_op(32'hFFFF0001, 32'h00010003, 1'b1, 1'b1, 1'b0);
    check_op("after_flush", 32'hFFFF0001, 32'h00010003, 1'b1, 1'b1);
    run_op(32'h00000003, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
    check_op("flush_done", 32'h00000003, 32'hFFFFFFFF, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    req_op1_i = 32'hDEADBEEF;
    req_op2_i = 32'h00001234;
    req_signed_i = 1'b0;
    req_to_hilo_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({req_ready_o, mul_start_o, result_valid_o, hilo_we_o,
         stallreq_o} !== 5'b10000 ||
        {mul_op1_o, mul_op2_o, result_o} !== 128'd0) begin
      fails++;
      $display("FAIL reset_mid_run got %b %h %h %h exp 10000 0",
        {req_ready_o, mul_start_o, result_valid_o, hilo_we_o,
         stallreq_o}, mul_op1_o, mul_op2_o, result_o);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(a, b, 1'b1, 1'(i), 1'b0);
      check_op($sformatf("b2b%0d", i), a, b, 1'b1, 1'(i));
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [4] = '{32'h0, 32'h1, 32'h80000000,
                                32'hFFFFFFFF};
    logic [31:0] a, b;
    logic        sg, th, fd;
    for (int i = 0; i < 25; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                      : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                      : $urandom;
      sg = 1'($urandom_range(0, 1));
      th = 1'($urandom_range(0, 1));
      fd = 1'($urandom_range(0, 1));
      run_op(a, b, sg, th, fd);
      check_op($sformatf("rnd%0d", i), a, b, sg, th);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_path();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
